nonce_tx_arbiter: RTL and testbench

NONCE_TX_ARBITER -- requirements
Module: nonce_tx_arbiter

---
 rtl/nonce_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_nonce_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_tx_arbiter.sv
// Round-robin collector of 32-bit nonces from SLAVES sources onto one serial transmitter.
// Edge at N -> pending at N+1 -> serial_send/golden_nonce at N+2; serial_busy holds off further grants.
module nonce_tx_arbiter #(
   parameter int SLAVES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SLAVES-1:0]    new_nonces,
   input  logic [SLAVES*32-1:0] slave_nonces,
   input  logic                 serial_busy,
   output logic                 serial_send,
   output logic [31:0]          golden_nonce,
   output logic [SLAVES-1:0]    pending,
   output logic [SLAVES-1:0]    overrun,
   output logic [CNT_W-1:0]     sent_count
);
   localparam int GW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            state_q;
   logic              serial_send_q;
   logic [31:0]       golden_q;
   logic [SLAVES-1:0] pending_q, pending_d;
   logic [SLAVES-1:0] overrun_q, overrun_d;
   logic [SLAVES-1:0] prev_q;
   logic [SLAVES-1:0] edge_v;
   logic [SLAVES-1:0] load;
   logic [CNT_W-1:0]  count_q;
   logic [GW-1:0]     last_q;
   logic [GW-1:0]     gsel;
   logic              gvalid;
   logic              do_grant;
   logic [31:0]       hold_q [SLAVES];

   assign edge_v = new_nonces & ~prev_q;

   // Round-robin search starting one past the previous winner.
   always_comb begin
      int          idx;
      logic [GW-1:0] cand;
      gvalid = 1'b0;
      gsel   = '0;
      idx    = 0;
      cand   = '0;
      for (int k = 1; k <= SLAVES; k++) begin
         idx  = (int'(last_q) + k) % SLAVES;
         cand = GW'(idx);
         if (!gvalid && pending_q[cand]) begin
            gvalid = 1'b1;
            gsel   = cand;
         end
      end
   end

   assign do_grant = (state_q == IDLE) && gvalid && !serial_busy;

   // A granted slot is freed first, so an edge arriving in its grant cycle reloads it cleanly.
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      load      = '0;
      for (int i = 0; i < SLAVES; i++) begin
         if (do_grant && (gsel == GW'(i))) begin
            pending_d[i] = 1'b0;
         end
         if (edge_v[i]) begin
            if (!pending_d[i]) begin
               load[i]      = 1'b1;
               pending_d[i] = 1'b1;
            end else begin
               overrun_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < SLAVES; i++) begin
         if (load[i]) begin
            hold_q[i] <= slave_nonces[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         serial_send_q <= 1'b0;
         golden_q      <= '0;
         pending_q     <= '0;
         overrun_q     <= '0;
         prev_q        <= '0;
         count_q       <= '0;
         last_q        <= GW'(SLAVES - 1);
      end else begin
         prev_q    <= new_nonces;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         case (state_q)
            IDLE: begin
               if (do_grant) begin
                  state_q       <= SEND;
                  serial_send_q <= 1'b1;
                  golden_q      <= hold_q[gsel];
                  last_q        <= gsel;
               end
            end
            SEND: begin
               state_q <= WAIT_BUSY;
               count_q <= count_q + 1'b1;
            end
            WAIT_BUSY: begin
               if (serial_busy) begin
                  state_q       <= WAIT_DONE;
                  serial_send_q <= 1'b0;
               end
            end
            WAIT_DONE: begin
               if (!serial_busy) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign serial_send  = serial_send_q;
   assign golden_nonce = golden_q;
   assign pending      = pending_q;
   assign overrun      = overrun_q;
   assign sent_count   = count_q;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Bench for nonce_tx_arbiter: directed scenarios plus random traffic against a timeline reference model.
module tb_nonce_tx_arbiter;
   localparam int NS = 3;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NS-1:0]     new_nonces = '0;
   logic [NS*32-1:0]  slave_nonces = '0;
   logic              serial_busy = 1'b0;
   logic              serial_send;
   logic [31:0]       golden_nonce;
   logic [NS-1:0]     pending;
   logic [NS-1:0]     overrun;
   logic [CW-1:0]     sent_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nonce_tx_arbiter #(.SLAVES(NS), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .new_nonces   (new_nonces),
      .slave_nonces (slave_nonces),
      .serial_busy  (serial_busy),
      .serial_send  (serial_send),
      .golden_nonce (golden_nonce),
      .pending      (pending),
      .overrun      (overrun),
      .sent_count   (sent_count)
   );

   // Transmitter: starts one cycle after it sees serial_send, stays busy for blen cycles.
   int          blen = 10;
   int          rem = 0;
   logic [31:0] got_q[$];

   always @(posedge clk) begin
      if (serial_busy) begin
         if (rem == 0) serial_busy <= 1'b0;
         else rem <= rem - 1;
      end else if (serial_send) begin
         serial_busy <= 1'b1;
         rem         <= blen - 1;
         got_q.push_back(golden_nonce);
      end
   end

   logic [NS-1:0] mpend, movr, mprev;
   logic [31:0]   mhold [NS];
   logic [31:0]   mgold;
   logic          msend;
   logic          mvalid = 1'b0;
   int            mlast, mcount;
   int            cyc = 0;
   int            gcyc = -1000;
   int            ok_cycle = 0;
   logic [31:0]   exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_got(input string tag, input int idx, input logic [31:0] exp);
      if (idx < got_q.size()) chk(tag, got_q[idx], exp);
      else chk({tag, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
   endtask

   function automatic logic [NS*32-1:0] rnd_sl();
      logic [NS*32-1:0] v;
      for (int i = 0; i < NS; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [NS*32-1:0] pk(input logic [31:0] w0, input logic [31:0] w1);
      logic [NS*32-1:0] v;
      v = '0;
      v[31:0]  = w0;
      v[63:32] = w1;
      return v;
   endfunction

   task automatic check_all();
      if (mvalid) begin
         chk("serial_send", 32'(serial_send), 32'(msend));
         chk("golden_nonce", golden_nonce, mgold);
         chk("pending", 32'(pending), 32'(mpend));
         chk("overrun", 32'(overrun), 32'(movr));
         chk("sent_count", 32'(sent_count), 32'(mcount));
      end
   endtask

   // Next grant allowed once the previous word's send/busy window (3+blen cycles) has elapsed and the line is quiet.
   task automatic apply(input logic [NS-1:0] nn, input logic [NS*32-1:0] sl, input logic rst);
      int g;
      new_nonces   = nn;
      slave_nonces = sl;
      reset        = rst;
      if (rst) begin
         mpend = '0; movr = '0; mprev = '0; mgold = '0; msend = 1'b0;
         mcount = 0; mlast = NS - 1; gcyc = -1000; ok_cycle = 0; mvalid = 1'b1;
      end else begin
         g = -1;
         if (cyc >= ok_cycle && !serial_busy && mpend != '0)
            for (int k = 1; k <= NS; k++)
               if (g < 0 && mpend[(mlast + k) % NS]) g = (mlast + k) % NS;
         msend = (cyc == gcyc + 1);
         if (cyc == gcyc + 1) mcount = (mcount + 1) % (1 << CW);
         if (g >= 0) begin
            exp_q.push_back(mhold[g]);
            mgold = mhold[g]; mpend[g] = 1'b0; mlast = g;
            gcyc = cyc; ok_cycle = cyc + 3 + blen; msend = 1'b1;
         end
         for (int i = 0; i < NS; i++)
            if (nn[i] && !mprev[i]) begin
               if (!mpend[i]) begin mhold[i] = sl[32*i +: 32]; mpend[i] = 1'b1; end
               else movr[i] = 1'b1;
            end
         mprev = nn;
      end
      cyc++;
   endtask

   task automatic step(input logic [NS-1:0] nn, input logic [NS*32-1:0] sl, input logic rst);
      @(negedge clk);
      check_all();
      apply(nn, sl, rst);
   endtask

   task automatic drain();
      int n = 0;
      while ((mpend != '0 || cyc <= ok_cycle || serial_busy || msend) && n < 400) begin
         step('0, rnd_sl(), 1'b0);
         n++;
      end
      chk("drain_bound", 32'(n >= 400), 32'd0);
   endtask

   task automatic step_on_grant(input logic [NS*32-1:0] sl);
      int   n = 0;
      logic hit = 1'b0;
      while (!hit && n < 200) begin
         @(negedge clk);
         check_all();
         if (cyc >= ok_cycle && !serial_busy && mpend != '0) begin
            apply(3'b001, sl, 1'b0);
            hit = 1'b1;
         end else begin
            apply('0, sl, 1'b0);
         end
         n++;
      end
      chk("grant_wait", 32'(hit), 32'd1);
   endtask

   initial begin
      int base;
      logic [NS-1:0] nn;

      step('0, '0, 1'b1);
      step('0, '0, 1'b1);
      @(posedge clk) #1;
      chk("rst_send", 32'(serial_send), 32'd0);
      chk("rst_golden", golden_nonce, 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_count", 32'(sent_count), 32'd0);

      // Single source latency
      blen = 10;
      base = got_q.size();
      step(3'b001, pk(32'hDEADBEEF, 32'h0), 1'b0);
      @(posedge clk) #1;
      chk("lat_pend_n1", 32'(pending[0]), 32'd1);
      chk("lat_send_n1", 32'(serial_send), 32'd0);
      step('0, rnd_sl(), 1'b0);
      @(posedge clk) #1;
      chk("lat_send_n2", 32'(serial_send), 32'd1);
      chk("lat_gold_n2", golden_nonce, 32'hDEADBEEF);
      drain();
      chk("single_count", 32'(sent_count), 32'd1);
      chk_got("single_word", base, 32'hDEADBEEF);

      // Simultaneous sources, repeated
      step('0, '0, 1'b1);
      base = got_q.size();
      step(3'b011, pk(32'h11111111, 32'h22222222), 1'b0);
      drain();
      step(3'b011, pk(32'h11111111, 32'h22222222), 1'b0);
      drain();
      chk_got("sim_a0", base, 32'h11111111);
      chk_got("sim_a1", base + 1, 32'h22222222);
      chk_got("sim_b0", base + 2, 32'h11111111);
      chk_got("sim_b1", base + 3, 32'h22222222);

      // Overrun while transmitter busy
      step('0, '0, 1'b1);
      base = got_q.size();
      step(3'b010, pk(32'h0, 32'h5A5A5A5A), 1'b0);
      repeat (4) step('0, rnd_sl(), 1'b0);
      step(3'b001, pk(32'h0000000A, 32'h0), 1'b0);
      step('0, rnd_sl(), 1'b0);
      step(3'b001, pk(32'h0000000B, 32'h0), 1'b0);
      drain();
      chk_got("ovr_w0", base, 32'h5A5A5A5A);
      chk_got("ovr_w1", base + 1, 32'h0000000A);
      chk("ovr_n", 32'(got_q.size() - base), 32'd2);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_pend", 32'(pending), 32'd0);

      // Edge arriving in its own grant cycle
      step('0, '0, 1'b1);
      base = got_q.size();
      step(3'b010, pk(32'h0, 32'h77777777), 1'b0);
      repeat (4) step('0, rnd_sl(), 1'b0);
      step(3'b001, pk(32'hAAAA0001, 32'h0), 1'b0);
      step('0, rnd_sl(), 1'b0);
      step_on_grant(pk(32'h0000000C, 32'h0));
      drain();
      chk_got("gc_w0", base, 32'h77777777);
      chk_got("gc_w1", base + 1, 32'hAAAA0001);
      chk_got("gc_w2", base + 2, 32'h0000000C);
      chk("gc_overrun", 32'(overrun), 32'd0);

      // Reset in WAIT_DONE with source 1 pending
      step('0, '0, 1'b1);
      base = got_q.size();
      step(3'b001, pk(32'h13579BDF, 32'h0), 1'b0);
      repeat (4) step('0, rnd_sl(), 1'b0);
      step(3'b010, pk(32'h0, 32'hBAD0BAD0), 1'b0);
      step('0, rnd_sl(), 1'b0);
      step('0, rnd_sl(), 1'b1);
      @(posedge clk) #1;
      chk("mrst_send", 32'(serial_send), 32'd0);
      chk("mrst_golden", golden_nonce, 32'd0);
      chk("mrst_pending", 32'(pending), 32'd0);
      chk("mrst_count", 32'(sent_count), 32'd0);
      step(3'b010, pk(32'h0, 32'h2468ACE0), 1'b0);
      drain();
      chk_got("mrst_w0", base, 32'h13579BDF);
      chk_got("mrst_w1", base + 1, 32'h2468ACE0);
      chk("mrst_n", 32'(got_q.size() - base), 32'd2);

      // Held level sends once
      step('0, '0, 1'b1);
      base = got_q.size();
      step(3'b001, pk(32'hC0FFEE00, 32'h0), 1'b0);
      repeat (19) step(3'b001, rnd_sl(), 1'b0);
      step('0, rnd_sl(), 1'b0);
      drain();
      chk("held_count", 32'(sent_count), 32'd1);
      chk_got("held_word", base, 32'hC0FFEE00);
      chk("held_n", 32'(got_q.size() - base), 32'd1);

      // Random traffic
      step('0, '0, 1'b1);
      for (int b = 0; b < 25; b++) begin
         blen = $urandom_range(1, 6);
         for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NS; i++) nn[i] = ($urandom_range(0, 3) == 0);
            step(nn, rnd_sl(), 1'b0);
         end
         drain();
      end

      chk("sb_size", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk("sb_word", got_q[i], exp_q[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
